// File: rtl/pipo_arb_pkg.sv
// Shared parameters and helpers for the round-robin PIPO write arbiter.
package pipo_arb_pkg;

  localparam int N_DEF    = 16;
  localparam int M_DEF    = 4;
  localparam int ONEHOT_W = 32;

  // Callers truncate the result to their own requester count.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    logic [ONEHOT_W-1:0] v;
    v = {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/pipo_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, circularly.
module pipo_rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int M = M_DEF,
  localparam int IDW = $clog2(M)
) (
  input  logic [M-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any
);

  logic [2*M-1:0] dbl_s;
  logic [2*M-1:0] one_s;
  logic [2*M-1:0] low_mask_s;
  logic [2*M-1:0] masked_s;

  // Doubling the vector turns the circular scan into a linear one above ptr.
  assign dbl_s      = {req, req};
  assign one_s      = {{(2*M-1){1'b0}}, 1'b1};
  assign low_mask_s = (one_s << ptr) - one_s;
  assign masked_s   = dbl_s & ~low_mask_s;
  assign any        = |req;

  // Lowest set bit of the masked vector wins; its low IDW bits give the index mod M.
  always_comb begin
    winner = {IDW{1'b0}};
    for (int i = 2*M-1; i >= 0; i--) begin
      if (masked_s[i]) begin
        winner = IDW'(i);
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin write arbiter feeding one shared PIPO register with a valid/ready output.
module pipo_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  localparam int IDW = $clog2(M)
) (
  input  logic           clk,
  input  logic           reset_ah_in,
  input  logic           en_in,
  input  logic [M-1:0]   req_in,
  input  logic [M*N-1:0] d_in,
  output logic [M-1:0]   ack_out,
  output logic [N-1:0]   q_out,
  output logic           q_valid_out,
  output logic [IDW-1:0] q_src_out,
  input  logic           q_ready_in
);

  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] winner_s;
  logic           any_s;
  logic           load_s;
  logic [N-1:0]   word_s;

  pipo_rr_pick #(.M(M)) u_pick (
    .req    (req_in),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // A load may overwrite a word that is being accepted in the same edge.
  assign load_s = en_in && any_s && (!q_valid_out || q_ready_in);

  // Select the winning requester's word.
  always_comb begin
    word_s = {N{1'b0}};
    for (int i = 0; i < M; i++) begin
      if (winner_s == IDW'(i)) begin
        word_s = d_in[i*N +: N];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Pointer, output register, source index and ack pulse.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      ptr_r       <= {IDW{1'b0}};
      q_out       <= {N{1'b0}};
      q_valid_out <= 1'b0;
      q_src_out   <= {IDW{1'b0}};
      ack_out     <= {M{1'b0}};
    end else if (load_s) begin
      ptr_r       <= winner_s + {{(IDW-1){1'b0}}, 1'b1};
      q_out       <= word_s;
      q_valid_out <= 1'b1;
      q_src_out   <= winner_s;
      ack_out     <= M'(onehot(int'(winner_s)));
    end else begin
      ack_out <= {M{1'b0}};
      if (q_valid_out && q_ready_in) begin
        q_valid_out <= 1'b0;
      end else begin
        q_valid_out <= q_valid_out;
      end
    end
  end

endmodule

// File: tb/tb_pipo_arbiter.sv
// Randomized and directed checks of pipo_arbiter against a behavioural model.
module tb_pipo_arbiter;

  localparam int N = 16;
  localparam int M = 4;

  logic          clk;
  logic          reset_ah_in;
  logic          en_in;
  logic [M-1:0]  req_in;
  logic [M*N-1:0] d_in;
  logic [M-1:0]  ack_out;
  logic [N-1:0]  q_out;
  logic          q_valid_out;
  logic [1:0]    q_src_out;
  logic          q_ready_in;

  int vectors;
  int miscompares;

  // model state
  int          m_ptr;
  logic [15:0] m_q;
  logic        m_v;
  int          m_src;
  logic [3:0]  m_ack;

  logic [15:0] words [4];
  logic [3:0]  pend;

  pipo_arbiter #(.N(N), .M(M)) dut (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .en_in       (en_in),
    .req_in      (req_in),
    .d_in        (d_in),
    .ack_out     (ack_out),
    .q_out       (q_out),
    .q_valid_out (q_valid_out),
    .q_src_out   (q_src_out),
    .q_ready_in  (q_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model, and compares after the edge.
  task automatic step(input logic rst, input logic en, input logic [3:0] req,
                      input logic [63:0] d, input logic rdy);
    int w;
    bit ld;
    @(negedge clk);
    reset_ah_in = rst;
    en_in       = en;
    req_in      = req;
    d_in        = d;
    q_ready_in  = rdy;
    if (rst) begin
      m_ptr = 0; m_q = 16'h0; m_v = 1'b0; m_src = 0; m_ack = 4'h0;
    end else begin
      ld = en && (req != 4'h0) && (!m_v || rdy);
      if (ld) begin
        w = -1;
        for (int k = 0; k < M; k++) begin
          if (w < 0 && req[(m_ptr + k) % M]) w = (m_ptr + k) % M;
        end
        m_q   = d[w*16 +: 16];
        m_src = w;
        m_v   = 1'b1;
        m_ack = 4'h0;
        m_ack[w] = 1'b1;
        m_ptr = (w + 1) % M;
      end else begin
        m_ack = 4'h0;
        if (m_v && rdy) m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("ack", 32'(ack_out), 32'(m_ack));
    check_eq("q_valid", 32'(q_valid_out), 32'(m_v));
    check_eq("q_src", 32'(q_src_out), 32'(m_src));
    check_eq("q", 32'(q_out), 32'(m_q));
  endtask

  function automatic logic [63:0] pack_words();
    return {words[3], words[2], words[1], words[0]};
  endfunction

  logic [63:0] dfix;
  logic [3:0]  r;

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_ah_in = 1'b1; en_in = 1'b0; req_in = 4'h0; d_in = 64'h0; q_ready_in = 1'b0;
    m_ptr = 0; m_q = 16'h0; m_v = 1'b0; m_src = 0; m_ack = 4'h0;
    dfix = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    // reset held for two cycles with all requests up
    step(1'b1, 1'b1, 4'b1111, dfix, 1'b1);
    step(1'b1, 1'b1, 4'b1111, dfix, 1'b1);
    check_eq("reset_q_lit", 32'(q_out), 32'h0);
    check_eq("reset_ack_lit", 32'(ack_out), 32'h0);

    // round-robin with everything requesting
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'b1111, dfix, 1'b1);
      check_eq("rr_src_lit", 32'(q_src_out), 32'(k % 4));
      check_eq("rr_q_lit", 32'(q_out), 32'h0000A000 + 32'(k % 4));
    end

    // backpressure: requester 1 wins, then output stalls
    step(1'b0, 1'b1, 4'b0110, dfix, 1'b1);
    check_eq("bp_first_lit", 32'(q_out), 32'h0000A001);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4'b0100, dfix, 1'b0);
      check_eq("bp_frozen_lit", 32'(q_out), 32'h0000A001);
      check_eq("bp_noack_lit", 32'(ack_out), 32'h0);
    end
    step(1'b0, 1'b1, 4'b0100, dfix, 1'b1);
    check_eq("bp_next_lit", 32'(q_src_out), 32'd2);

    // simultaneous accept and load
    step(1'b0, 1'b1, 4'b1000, dfix, 1'b1);
    check_eq("sim_ack_lit", 32'(ack_out), 32'h8);
    check_eq("sim_q_lit", 32'(q_out), 32'h0000A003);

    // disabled: word drains, no new grant; enable grants requester 0
    step(1'b0, 1'b0, 4'b0001, dfix, 1'b1);
    check_eq("en_drain_lit", 32'(q_valid_out), 32'h0);
    step(1'b0, 1'b1, 4'b0001, dfix, 1'b1);
    check_eq("en_ack_lit", 32'(ack_out), 32'h1);

    // reset while a stalled word is held
    step(1'b0, 1'b1, 4'b0010, dfix, 1'b0);
    step(1'b0, 1'b1, 4'b0000, dfix, 1'b0);
    step(1'b1, 1'b1, 4'b0100, dfix, 1'b0);
    check_eq("mrst_valid_lit", 32'(q_valid_out), 32'h0);
    step(1'b0, 1'b1, 4'b1111, dfix, 1'b1);
    check_eq("mrst_ptr_lit", 32'(q_src_out), 32'd0);

    // randomized traffic with requesters holding data until acknowledged
    pend = 4'h0;
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          words[i] = 16'($urandom);
        end
      end
      r = pend;
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) != 0), r, pack_words(),
           ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) begin
          pend[i] = ($urandom_range(0, 1) == 1);
          words[i] = 16'($urandom);
        end
      end
      if (reset_ah_in) pend = 4'h0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
